// File: rtl/door_lock_pkg.sv
// Shared types and constants for the two-panel door-lock arbiter.
package door_lock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_A   = 2'd1,
    OWN_B   = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  localparam logic       PANEL_A         = 1'b0;
  localparam logic       PANEL_B         = 1'b1;
  localparam int         DEFAULT_DIGIT_W = 4;
  localparam logic [1:0] MAX_DIGITS      = 2'd3;

endpackage

// File: rtl/keypad_edge_detect.sv
// Rising-edge detector for one debounced button level; the previous sample
// resets high so a button held through reset is not seen as a press.
module keypad_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic press
);

  logic prev_r;

  // previous-sample register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r <= 1'b1;
    end else begin
      prev_r <= level;
    end
  end

  assign press = level & ~prev_r;

endmodule

// File: rtl/door_lock_panel_arbiter.sv
// Shares one door-lock core between keypad panels A and B: session ownership,
// round-robin tie-break, digit counting, inactivity timeout and strobe outputs.
module door_lock_panel_arbiter
  import door_lock_pkg::*;
#(
  parameter int TIMEOUT = 500,
  parameter int DIGIT_W = DEFAULT_DIGIT_W
) (
  input  logic               i_clk,
  input  logic               i_hard_reset_n,
  input  logic [DIGIT_W-1:0] i_digit_a,
  input  logic [DIGIT_W-1:0] i_digit_b,
  input  logic               i_confirm_getter_a,
  input  logic               i_confirm_getter_b,
  input  logic               i_confirm_fsm_a,
  input  logic               i_confirm_fsm_b,
  output logic [DIGIT_W-1:0] o_digit,
  output logic               o_confirm_getter,
  output logic               o_confirm_fsm,
  output logic               o_grant_a,
  output logic               o_grant_b,
  output logic [1:0]         o_digit_count,
  output logic               o_timeout,
  output logic               o_reject
);

  localparam int INACT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic ga_s, gb_s, ca_s, cb_s;

  keypad_edge_detect u_edge_ga (.clk(i_clk), .rst_n(i_hard_reset_n), .level(i_confirm_getter_a), .press(ga_s));
  keypad_edge_detect u_edge_gb (.clk(i_clk), .rst_n(i_hard_reset_n), .level(i_confirm_getter_b), .press(gb_s));
  keypad_edge_detect u_edge_ca (.clk(i_clk), .rst_n(i_hard_reset_n), .level(i_confirm_fsm_a), .press(ca_s));
  keypad_edge_detect u_edge_cb (.clk(i_clk), .rst_n(i_hard_reset_n), .level(i_confirm_fsm_b), .press(cb_s));

  arb_state_t         state_r, state_nxt_s;
  logic               ptr_r, ptr_nxt_s;
  logic [1:0]         count_r, count_nxt_s;
  logic [INACT_W-1:0] inact_r, inact_nxt_s;
  logic [DIGIT_W-1:0] digit_r, digit_nxt_s;
  logic               cg_r, cg_nxt_s;
  logic               cf_r, cf_nxt_s;
  logic               to_r, to_nxt_s;
  logic               rej_r, rej_nxt_s;
  logic               grant_a_r, grant_b_r;

  logic               win_s;
  logic               own_g_s, own_c_s, other_s;
  logic [DIGIT_W-1:0] own_digit_s;

  // next-state, counters and strobe decode
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    count_nxt_s = count_r;
    inact_nxt_s = inact_r;
    digit_nxt_s = digit_r;
    cg_nxt_s    = 1'b0;
    cf_nxt_s    = 1'b0;
    to_nxt_s    = 1'b0;
    rej_nxt_s   = 1'b0;
    win_s       = PANEL_A;
    own_g_s     = 1'b0;
    own_c_s     = 1'b0;
    other_s     = 1'b0;
    own_digit_s = i_digit_a;

    case (state_r)
      IDLE: begin
        count_nxt_s = 2'd0;
        inact_nxt_s = '0;
        if (ga_s && gb_s) begin
          win_s = ptr_r;
        end else if (gb_s) begin
          win_s = PANEL_B;
        end else begin
          win_s = PANEL_A;
        end
        if (ga_s || gb_s) begin
          state_nxt_s = (win_s == PANEL_A) ? OWN_A : OWN_B;
          digit_nxt_s = (win_s == PANEL_A) ? i_digit_a : i_digit_b;
          cg_nxt_s    = 1'b1;
          count_nxt_s = 2'd1;
          ptr_nxt_s   = ~win_s;
          // the losing getter of a tie is dropped just like a stray confirm
          rej_nxt_s   = (ga_s && gb_s) || ca_s || cb_s;
        end else begin
          rej_nxt_s   = ca_s || cb_s;
        end
      end

      OWN_A, OWN_B: begin
        if (state_r == OWN_A) begin
          own_g_s     = ga_s;
          own_c_s     = ca_s;
          other_s     = gb_s || cb_s;
          own_digit_s = i_digit_a;
        end else begin
          own_g_s     = gb_s;
          own_c_s     = cb_s;
          other_s     = ga_s || ca_s;
          own_digit_s = i_digit_b;
        end
        rej_nxt_s = other_s;
        if (own_g_s) begin
          inact_nxt_s = '0;
          if (count_r < MAX_DIGITS) begin
            digit_nxt_s = own_digit_s;
            cg_nxt_s    = 1'b1;
            count_nxt_s = count_r + 2'd1;
            rej_nxt_s   = other_s || own_c_s;
          end else begin
            rej_nxt_s   = 1'b1;
          end
        end else if (own_c_s) begin
          cf_nxt_s    = 1'b1;
          state_nxt_s = RELEASE;
          count_nxt_s = 2'd0;
          inact_nxt_s = '0;
        end else if (inact_r == INACT_W'(TIMEOUT - 1)) begin
          to_nxt_s    = 1'b1;
          state_nxt_s = RELEASE;
          count_nxt_s = 2'd0;
          inact_nxt_s = '0;
        end else begin
          inact_nxt_s = inact_r + INACT_W'(1);
        end
      end

      RELEASE: begin
        rej_nxt_s   = ga_s || gb_s || ca_s || cb_s;
        count_nxt_s = 2'd0;
        inact_nxt_s = '0;
        state_nxt_s = IDLE;
      end

      default: begin
        state_nxt_s = IDLE;
        count_nxt_s = 2'd0;
        inact_nxt_s = '0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge i_clk or negedge i_hard_reset_n) begin
    if (!i_hard_reset_n) begin
      state_r   <= IDLE;
      ptr_r     <= PANEL_A;
      count_r   <= 2'd0;
      inact_r   <= '0;
      digit_r   <= '0;
      cg_r      <= 1'b0;
      cf_r      <= 1'b0;
      to_r      <= 1'b0;
      rej_r     <= 1'b0;
      grant_a_r <= 1'b0;
      grant_b_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      ptr_r     <= ptr_nxt_s;
      count_r   <= count_nxt_s;
      inact_r   <= inact_nxt_s;
      digit_r   <= digit_nxt_s;
      cg_r      <= cg_nxt_s;
      cf_r      <= cf_nxt_s;
      to_r      <= to_nxt_s;
      rej_r     <= rej_nxt_s;
      grant_a_r <= (state_nxt_s == OWN_A);
      grant_b_r <= (state_nxt_s == OWN_B);
    end
  end

  assign o_digit          = digit_r;
  assign o_confirm_getter = cg_r;
  assign o_confirm_fsm    = cf_r;
  assign o_grant_a        = grant_a_r;
  assign o_grant_b        = grant_b_r;
  assign o_digit_count    = count_r;
  assign o_timeout        = to_r;
  assign o_reject         = rej_r;

endmodule

// File: tb/tb_door_lock_panel_arbiter.sv
// Directed bench for door_lock_panel_arbiter with TIMEOUT = 20.
module tb_door_lock_panel_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] digit_a, digit_b;
  logic       ga, gb, ca, cb;
  logic [3:0] o_digit;
  logic       o_cg, o_cf, o_grant_a, o_grant_b, o_timeout, o_reject;
  logic [1:0] o_count;

  int vectors = 0;
  int fails   = 0;

  door_lock_panel_arbiter #(.TIMEOUT(20), .DIGIT_W(4)) dut (
    .i_clk              (clk),
    .i_hard_reset_n     (rst_n),
    .i_digit_a          (digit_a),
    .i_digit_b          (digit_b),
    .i_confirm_getter_a (ga),
    .i_confirm_getter_b (gb),
    .i_confirm_fsm_a    (ca),
    .i_confirm_fsm_b    (cb),
    .o_digit            (o_digit),
    .o_confirm_getter   (o_cg),
    .o_confirm_fsm      (o_cf),
    .o_grant_a          (o_grant_a),
    .o_grant_b          (o_grant_b),
    .o_digit_count      (o_count),
    .o_timeout          (o_timeout),
    .o_reject           (o_reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; digit_a = 4'h0; digit_b = 4'h0;
    ga = 1'b1; gb = 1'b1; ca = 1'b0; cb = 1'b0;
    repeat (3) tick();
    check("rst_grant_a", o_grant_a, 1'b0);
    check("rst_grant_b", o_grant_b, 1'b0);
    check("rst_digit", o_digit, 4'h0);
    check("rst_count", o_count, 2'd0);
    check("rst_strobes", {o_cg, o_cf, o_timeout, o_reject}, 4'b0000);

    // getters held through reset deassertion must not count as presses
    rst_n = 1'b1;
    tick();
    check("held_no_grant", {o_grant_a, o_grant_b}, 2'b00);
    check("held_no_strobe", {o_cg, o_reject}, 2'b00);
    ga = 1'b0; gb = 1'b0;
    tick();

    // simultaneous press after reset: pointer at A
    digit_a = 4'hB; digit_b = 4'h3; ga = 1'b1; gb = 1'b1;
    tick();
    check("tie1_grant", {o_grant_a, o_grant_b}, 2'b10);
    check("tie1_digit", o_digit, 4'hB);
    check("tie1_cg", o_cg, 1'b1);
    check("tie1_count", o_count, 2'd1);
    tick();
    check("held_no_restrobe", o_cg, 1'b0);
    check("held_grant", o_grant_a, 1'b1);
    ga = 1'b0; gb = 1'b0;
    tick();

    digit_a = 4'hA; ga = 1'b1;
    tick();
    check("d2_digit", o_digit, 4'hA);
    check("d2_count", o_count, 2'd2);
    check("d2_cg", o_cg, 1'b1);
    ga = 1'b0;
    tick();

    // intruding press from B while A owns
    digit_b = 4'h7; gb = 1'b1;
    tick();
    check("intr_reject", o_reject, 1'b1);
    check("intr_digit", o_digit, 4'hA);
    check("intr_count", o_count, 2'd2);
    check("intr_cg", o_cg, 1'b0);
    check("intr_grant", {o_grant_a, o_grant_b}, 2'b10);
    gb = 1'b0;
    tick();
    check("intr_reject_1cyc", o_reject, 1'b0);

    digit_a = 4'hD; ga = 1'b1;
    tick();
    check("d3_digit", o_digit, 4'hD);
    check("d3_count", o_count, 2'd3);
    ga = 1'b0;
    tick();

    digit_a = 4'h6; ga = 1'b1;
    tick();
    check("d4_reject", o_reject, 1'b1);
    check("d4_cg", o_cg, 1'b0);
    check("d4_digit", o_digit, 4'hD);
    check("d4_count", o_count, 2'd3);
    ga = 1'b0;
    tick();

    ca = 1'b1;
    tick();
    check("conf_cf", o_cf, 1'b1);
    check("conf_grant_drop", o_grant_a, 1'b0);
    check("conf_count", o_count, 2'd0);
    ca = 1'b0;
    tick();
    check("release_cf", o_cf, 1'b0);
    check("release_grant", {o_grant_a, o_grant_b}, 2'b00);
    check("release_reject", o_reject, 1'b0);

    // second tie: pointer now favours B
    digit_a = 4'h1; digit_b = 4'h5; ga = 1'b1; gb = 1'b1;
    tick();
    check("tie2_grant", {o_grant_a, o_grant_b}, 2'b01);
    check("tie2_digit", o_digit, 4'h5);
    check("tie2_count", o_count, 2'd1);
    ga = 1'b0; gb = 1'b0;
    tick();
    cb = 1'b1;
    tick();
    check("b_conf_cf", o_cf, 1'b1);
    check("b_conf_grant", o_grant_b, 1'b0);
    cb = 1'b0;
    tick();

    // timeout: one digit then silence
    digit_a = 4'h2; ga = 1'b1;
    tick();
    check("to_grant", o_grant_a, 1'b1);
    ga = 1'b0;
    repeat (18) tick();
    tick();
    check("to_not_early", o_timeout, 1'b0);
    check("to_grant_held", o_grant_a, 1'b1);
    tick();
    check("to_fire", o_timeout, 1'b1);
    check("to_no_cf", o_cf, 1'b0);
    check("to_grant_drop", o_grant_a, 1'b0);
    ga = 1'b1;
    tick();
    check("rel_press_reject", o_reject, 1'b1);
    check("rel_press_no_grant", {o_grant_a, o_grant_b}, 2'b00);
    check("to_pulse_1cyc", o_timeout, 1'b0);
    ga = 1'b0; digit_b = 4'h9; gb = 1'b1;
    tick();
    check("after_to_grant_b", {o_grant_a, o_grant_b}, 2'b01);
    check("after_to_digit", o_digit, 4'h9);
    gb = 1'b0;
    tick();
    digit_b = 4'h4; gb = 1'b1;
    tick();
    check("b_d2_count", o_count, 2'd2);
    gb = 1'b0;

    // asynchronous reset mid-session
    #2 rst_n = 1'b0;
    #1;
    check("arst_grant", {o_grant_a, o_grant_b}, 2'b00);
    check("arst_count", o_count, 2'd0);
    check("arst_digit", o_digit, 4'h0);
    check("arst_strobes", {o_cg, o_cf, o_timeout, o_reject}, 4'b0000);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_release_quiet", {o_cg, o_reject, o_grant_a, o_grant_b}, 4'b0000);
    digit_a = 4'h8; ga = 1'b1;
    tick();
    check("fresh_grant", {o_grant_a, o_grant_b}, 2'b10);
    check("fresh_count", o_count, 2'd1);
    check("fresh_digit", o_digit, 4'h8);
    ga = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
